// File: rtl/nlprg_pkg.sv
// Shared definitions for the nonlinear pseudo-random generator family:
// legal width range and the per-width primitive feedback tap masks.
package nlprg_pkg;

   localparam int NLPRG_MIN_N = 3;
   localparam int NLPRG_MAX_N = 16;

   // Primitive tap mask for an n-bit shift-left generator (bit n-1 always set).
   function automatic logic [NLPRG_MAX_N-1:0] nlprg_taps(input int n);
      logic [NLPRG_MAX_N-1:0] t;
      case (n)
         32'd3:   t = 16'h0006;
         32'd4:   t = 16'h000C;
         32'd5:   t = 16'h0014;
         32'd6:   t = 16'h0030;
         32'd7:   t = 16'h0060;
         32'd8:   t = 16'h00B8;
         32'd9:   t = 16'h0110;
         32'd10:  t = 16'h0240;
         32'd11:  t = 16'h0500;
         32'd12:  t = 16'h0829;
         32'd13:  t = 16'h100D;
         32'd14:  t = 16'h2015;
         32'd15:  t = 16'h6000;
         32'd16:  t = 16'hD008;
         default: t = 16'h0000;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/nlprg_chk.sv
// Period checker: counts accepted samples modulo 2^N, expects the all-zero
// state exactly when the count is zero, and pulses wrap at each full period.
// After a seed load it stays disarmed until the zero state is seen again.
module nlprg_chk
   import nlprg_pkg::*;
#(
   parameter int unsigned N = 9
) (
   input  logic ck,
   input  logic rst,
   input  logic transfer_i,
   input  logic o_is_zero_i,
   input  logic seed_ld_i,
   output logic wrap_o,
   output logic period_err_o
);

   logic [N-1:0] cnt_q, cnt_d;
   logic         armed_q, armed_d;
   logic         wrap_q, wrap_d;
   logic         err_q, err_d;

   // Next-state for count, arming, wrap pulse and sticky error.
   always_comb begin
      cnt_d   = cnt_q;
      armed_d = armed_q;
      wrap_d  = 1'b0;
      err_d   = err_q;
      if (seed_ld_i) begin
         armed_d = 1'b0;
      end else if (transfer_i) begin
         if (armed_q) begin
            if (o_is_zero_i != (cnt_q == {N{1'b0}})) begin
               err_d = 1'b1;
            end else begin
               err_d = err_q;
            end
            cnt_d  = cnt_q + {{(N-1){1'b0}}, 1'b1};
            wrap_d = (cnt_q == {N{1'b1}});
         end else if (o_is_zero_i) begin
            // Resync: the zero sample just accepted is count 0 of a new period.
            armed_d = 1'b1;
            cnt_d   = {{(N-1){1'b0}}, 1'b1};
         end else begin
            cnt_d = cnt_q;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Checker state registers; only rst clears the sticky error.
   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         cnt_q   <= {N{1'b0}};
         armed_q <= 1'b1;
         wrap_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         armed_q <= armed_d;
         wrap_q  <= wrap_d;
         err_q   <= err_d;
      end
   end

   assign wrap_o       = wrap_q;
   assign period_err_o = err_q;

endmodule

// File: rtl/nlprg_gen.sv
// N-bit full-period (de Bruijn) nonlinear generator with seed load, a
// ready/valid output handshake and an optional built-in period checker.
module nlprg_gen
   import nlprg_pkg::*;
#(
   parameter int unsigned   N     = 9,
   parameter logic [N-1:0]  TAPS  = N'(nlprg_taps(N)),
   parameter bit            CHECK = 1'b1
) (
   input  logic         ck,
   input  logic         rst,
   input  logic         seed_ld,
   input  logic [N-1:0] seed,
   input  logic         o_ready,
   output logic         o_valid,
   output logic [N-1:0] o,
   output logic         wrap,
   output logic         period_err
);

   logic [N-1:0] state_q, state_d;
   logic         valid_q;
   logic         lin_s, zero_low_s, fb_s, transfer_s;
   logic [N-1:0] next_s;

   // Linear feedback plus the zero-insertion term that splices 0..0 into the cycle.
   always_comb begin
      lin_s      = ^(state_q & TAPS);
      zero_low_s = (state_q[N-2:0] == {(N-1){1'b0}});
      fb_s       = lin_s ^ zero_low_s;
      next_s     = {state_q[N-2:0], fb_s};
   end

   assign o_valid    = valid_q & ~seed_ld;
   assign transfer_s = o_valid & o_ready;

   // State selection: seed load wins, then an accepted transfer, else hold.
   always_comb begin
      state_d = state_q;
      if (seed_ld) begin
         state_d = seed;
      end else if (transfer_s) begin
         state_d = next_s;
      end else begin
         state_d = state_q;
      end
   end

   // Generator state and the output-valid flag.
   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         state_q <= {N{1'b0}};
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         valid_q <= 1'b1;
      end
   end

   assign o = state_q;

   if (CHECK) begin : g_chk
      logic o_is_zero_s;
      assign o_is_zero_s = (state_q == {N{1'b0}});
      nlprg_chk #(.N(N)) u_chk (
         .ck           (ck),
         .rst          (rst),
         .transfer_i   (transfer_s),
         .o_is_zero_i  (o_is_zero_s),
         .seed_ld_i    (seed_ld),
         .wrap_o       (wrap),
         .period_err_o (period_err)
      );
   end else begin : g_nochk
      assign wrap       = 1'b0;
      assign period_err = 1'b0;
   end

endmodule
